// File: rtl/l2k_ptw.sv
// Two-level page-table walker for the Limn2600 MMU: turns a TLB miss into a PDE read,
// a PTE read and a TLB fill, or a fault pulse.
module l2k_ptw #(
    parameter int unsigned NUM_ENTRIES = 128,
    parameter int unsigned WIRED       = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [31:0]                    pgtb_i,
    input  logic [11:0]                    asid_i,
    input  logic                           flush_i,
    input  logic                           miss_valid_i,
    output logic                           miss_ready_o,
    input  logic [31:0]                    miss_va_i,
    input  logic                           miss_write_i,
    output logic                           mem_req_o,
    output logic [31:0]                    mem_addr_o,
    input  logic                           mem_ack_i,
    input  logic [31:0]                    mem_rdata_i,
    input  logic                           mem_err_i,
    output logic                           fill_valid_o,
    input  logic                           fill_ready_i,
    output logic [$clog2(NUM_ENTRIES)-1:0] fill_index_o,
    output logic [31:0]                    fill_hi_o,
    output logic [31:0]                    fill_lo_o,
    output logic                           fault_valid_o,
    output logic [1:0]                     fault_code_o,
    output logic [31:0]                    fault_addr_o,
    output logic                           fault_write_o
);
    localparam int unsigned IdxW = $clog2(NUM_ENTRIES);
    localparam logic [IdxW-1:0] IdxFirst = IdxW'(WIRED);
    localparam logic [IdxW-1:0] IdxLast  = IdxW'(NUM_ENTRIES - 1);

    typedef enum logic [2:0] {StIdle, StPde, StPte, StFill, StFault, StDrain} state_e;

    state_e          state_q;
    logic            miss_ready_q;
    logic            mem_req_q;
    logic [31:0]     mem_addr_q;
    logic            fill_valid_q;
    logic [IdxW-1:0] fill_index_q;
    logic [31:0]     fill_hi_q;
    logic [31:0]     fill_lo_q;
    logic            fault_valid_q;
    logic [1:0]      fault_code_q;
    logic [31:0]     va_q;
    logic            write_q;
    logic [11:0]     asid_q;
    logic [IdxW-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            miss_ready_q  <= 1'b1;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
            fill_valid_q  <= 1'b0;
            fill_index_q  <= '0;
            fill_hi_q     <= '0;
            fill_lo_q     <= '0;
            fault_valid_q <= 1'b0;
            fault_code_q  <= '0;
            va_q          <= '0;
            write_q       <= 1'b0;
            asid_q        <= '0;
            cnt_q         <= IdxFirst;
        end else begin
            fault_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (miss_valid_i && miss_ready_q) begin
                        va_q         <= miss_va_i;
                        write_q      <= miss_write_i;
                        asid_q       <= asid_i;
                        miss_ready_q <= 1'b0;
                        mem_req_q    <= 1'b1;
                        mem_addr_q   <= {pgtb_i[31:12], miss_va_i[31:22], 2'b00};
                        state_q      <= StPde;
                    end
                end
                StPde, StPte: begin
                    if (flush_i) begin
                        // A pending read cannot be retracted; wait out its ack in drain.
                        if (mem_ack_i) begin
                            mem_req_q    <= 1'b0;
                            miss_ready_q <= 1'b1;
                            state_q      <= StIdle;
                        end else begin
                            state_q <= StDrain;
                        end
                    end else if (mem_ack_i) begin
                        if (mem_err_i || !mem_rdata_i[0]) begin
                            mem_req_q     <= 1'b0;
                            fault_valid_q <= 1'b1;
                            fault_code_q  <= mem_err_i ? 2'd3 :
                                             (state_q == StPde) ? 2'd1 : 2'd2;
                            state_q       <= StFault;
                        end else if (state_q == StPde) begin
                            mem_addr_q <= {mem_rdata_i[24:5], va_q[21:12], 2'b00};
                            state_q    <= StPte;
                        end else begin
                            mem_req_q    <= 1'b0;
                            fill_valid_q <= 1'b1;
                            fill_index_q <= cnt_q;
                            fill_hi_q    <= {va_q[31:12], asid_q};
                            fill_lo_q    <= mem_rdata_i;
                            state_q      <= StFill;
                        end
                    end
                end
                StFill: begin
                    if (flush_i || fill_ready_i) begin
                        fill_valid_q <= 1'b0;
                        miss_ready_q <= 1'b1;
                        state_q      <= StIdle;
                        if (!flush_i) begin
                            cnt_q <= (cnt_q == IdxLast) ? IdxFirst : cnt_q + 1'b1;
                        end
                    end
                end
                StFault: begin
                    miss_ready_q <= 1'b1;
                    state_q      <= StIdle;
                end
                StDrain: begin
                    if (mem_ack_i) begin
                        mem_req_q    <= 1'b0;
                        miss_ready_q <= 1'b1;
                        state_q      <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign miss_ready_o  = miss_ready_q;
    assign mem_req_o     = mem_req_q;
    assign mem_addr_o    = mem_addr_q;
    assign fill_valid_o  = fill_valid_q;
    assign fill_index_o  = fill_index_q;
    assign fill_hi_o     = fill_hi_q;
    assign fill_lo_o     = fill_lo_q;
    assign fault_valid_o = fault_valid_q;
    assign fault_code_o  = fault_code_q;
    assign fault_addr_o  = va_q;
    assign fault_write_o = write_q;

    logic unused_bits;
    assign unused_bits = ^{pgtb_i[11:0], mem_rdata_i[31:25], mem_rdata_i[4:1]};

endmodule

// File: tb/tb_l2k_ptw.sv
// Directed bench for l2k_ptw: walks, faults, replacement wrap, back-pressure, flush and reset.
module tb_l2k_ptw;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pgtb;
    logic [11:0] asid;
    logic        flush;
    logic        miss_valid;
    logic        miss_ready;
    logic [31:0] miss_va;
    logic        miss_write;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        mem_err;
    logic        fill_valid;
    logic        fill_ready;
    logic [6:0]  fill_index;
    logic [31:0] fill_hi;
    logic [31:0] fill_lo;
    logic        fault_valid;
    logic [1:0]  fault_code;
    logic [31:0] fault_addr;
    logic        fault_write;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    l2k_ptw dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .pgtb_i       (pgtb),
        .asid_i       (asid),
        .flush_i      (flush),
        .miss_valid_i (miss_valid),
        .miss_ready_o (miss_ready),
        .miss_va_i    (miss_va),
        .miss_write_i (miss_write),
        .mem_req_o    (mem_req),
        .mem_addr_o   (mem_addr),
        .mem_ack_i    (mem_ack),
        .mem_rdata_i  (mem_rdata),
        .mem_err_i    (mem_err),
        .fill_valid_o (fill_valid),
        .fill_ready_i (fill_ready),
        .fill_index_o (fill_index),
        .fill_hi_o    (fill_hi),
        .fill_lo_o    (fill_lo),
        .fault_valid_o(fault_valid),
        .fault_code_o (fault_code),
        .fault_addr_o (fault_addr),
        .fault_write_o(fault_write)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the first PDE cycle.
    task automatic start_miss(input logic [31:0] va, input logic wr);
        int budget = 20;
        while (!miss_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (!miss_ready) check("miss_ready_wait", 32'(miss_ready), 32'd1);
        miss_valid = 1'b1;
        miss_va    = va;
        miss_write = wr;
        @(negedge clk);
        miss_valid = 1'b0;
        miss_write = 1'b0;
    endtask

    task automatic mem_reply(input logic [31:0] data, input logic err);
        mem_ack   = 1'b1;
        mem_rdata = data;
        mem_err   = err;
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = '0;
        mem_err   = 1'b0;
    endtask

    // Zero-wait walk; returns at the negedge of the fill cycle.
    task automatic walk(input logic [31:0] va, input logic [31:0] pde, input logic [31:0] pte);
        start_miss(va, 1'b0);
        check("walk_pde_req", 32'(mem_req), 32'd1);
        mem_reply(pde, 1'b0);
        check("walk_pte_req", 32'(mem_req), 32'd1);
        mem_reply(pte, 1'b0);
    endtask

    initial begin
        int exp_idx;
        int low_hits;
        rst_n = 1'b0; pgtb = 32'h0010_0000; asid = 12'h005; flush = 1'b0;
        miss_valid = 1'b0; miss_va = '0; miss_write = 1'b0;
        mem_ack = 1'b0; mem_rdata = '0; mem_err = 1'b0; fill_ready = 1'b0;
        #12;
        check("rst_miss_ready", 32'(miss_ready), 32'd1);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_fill_valid", 32'(fill_valid), 32'd0);
        check("rst_fault_valid", 32'(fault_valid), 32'd0);
        check("rst_fault_addr", fault_addr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic walk with exact cycle latency.
        start_miss(32'h0040_3ABC, 1'b0);
        check("basic_pde_req", 32'(mem_req), 32'd1);
        check("basic_pde_addr", mem_addr, 32'h0010_0004);
        mem_reply(32'h0000_4001, 1'b0);
        check("basic_pte_req", 32'(mem_req), 32'd1);
        check("basic_pte_addr", mem_addr, 32'h0020_000C);
        mem_reply(32'h0000_0A13, 1'b0);
        check("basic_fill_valid", 32'(fill_valid), 32'd1);
        check("basic_fill_index", 32'(fill_index), 32'd4);
        check("basic_fill_hi", fill_hi, 32'h0040_3005);
        check("basic_fill_lo", fill_lo, 32'h0000_0A13);
        check("basic_req_low", 32'(mem_req), 32'd0);
        fill_ready = 1'b1;
        @(negedge clk);
        fill_ready = 1'b0;
        check("basic_fill_done", 32'(fill_valid), 32'd0);
        check("basic_idle_ready", 32'(miss_ready), 32'd1);

        // Invalid PDE.
        start_miss(32'h1234_5678, 1'b0);
        mem_reply(32'h0000_4000, 1'b0);
        check("pde_inv_fault", 32'(fault_valid), 32'd1);
        check("pde_inv_code", 32'(fault_code), 32'd1);
        check("pde_inv_addr", fault_addr, 32'h1234_5678);
        check("pde_inv_req", 32'(mem_req), 32'd0);
        @(negedge clk);
        check("pde_inv_pulse", 32'(fault_valid), 32'd0);
        check("pde_inv_ready", 32'(miss_ready), 32'd1);

        // Invalid PTE.
        start_miss(32'h0040_3ABC, 1'b0);
        mem_reply(32'h0000_4001, 1'b0);
        mem_reply(32'h0000_0A12, 1'b0);
        check("pte_inv_fault", 32'(fault_valid), 32'd1);
        check("pte_inv_code", 32'(fault_code), 32'd2);
        check("pte_inv_fill", 32'(fill_valid), 32'd0);
        @(negedge clk);
        check("pte_inv_pulse", 32'(fault_valid), 32'd0);

        // Bus error on the PTE read from a store.
        start_miss(32'h0080_1000, 1'b1);
        mem_reply(32'h0000_4001, 1'b0);
        mem_reply(32'h0000_0A13, 1'b1);
        check("err_fault", 32'(fault_valid), 32'd1);
        check("err_code", 32'(fault_code), 32'd3);
        check("err_write", 32'(fault_write), 32'd1);
        check("err_addr", fault_addr, 32'h0080_1000);
        check("err_fill", 32'(fill_valid), 32'd0);
        @(negedge clk);
        check("err_no_fill", 32'(fill_valid), 32'd0);

        // Back-pressure then flush in FILL; faults above must not have advanced the counter.
        walk(32'h0040_3ABC, 32'h0000_4001, 32'h0000_0A13);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(fill_valid), 32'd1);
            check("bp_index", 32'(fill_index), 32'd5);
            check("bp_hi", fill_hi, 32'h0040_3005);
            check("bp_lo", fill_lo, 32'h0000_0A13);
            @(negedge clk);
        end
        flush = 1'b1;
        fill_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        fill_ready = 1'b0;
        check("flush_fill_valid", 32'(fill_valid), 32'd0);
        check("flush_fill_ready", 32'(miss_ready), 32'd1);

        // Replacement wrap with fill_ready held: 5..127, then 4.
        fill_ready = 1'b1;
        exp_idx = 5;
        low_hits = 0;
        for (int i = 0; i < 124; i++) begin
            walk(32'h0040_3ABC, 32'h0000_4001, 32'h0000_0A13);
            check("wrap_index", 32'(fill_index), 32'(exp_idx));
            if (fill_index < 7'd4) low_hits++;
            exp_idx = (exp_idx == 127) ? 4 : exp_idx + 1;
            @(negedge clk);
            check("wrap_one_cycle", 32'(fill_valid), 32'd0);
        end
        check("wrap_no_wired", 32'(low_hits), 32'd0);
        fill_ready = 1'b0;

        // Flush during PTE with ack delayed three cycles.
        start_miss(32'h0040_3ABC, 1'b0);
        mem_reply(32'h0000_4001, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("drain_req", 32'(mem_req), 32'd1);
            check("drain_addr", mem_addr, 32'h0020_000C);
            check("drain_busy", 32'(miss_ready), 32'd0);
            @(negedge clk);
        end
        check("drain_req_last", 32'(mem_req), 32'd1);
        mem_reply(32'h0000_0A13, 1'b0);
        check("drain_req_done", 32'(mem_req), 32'd0);
        check("drain_ready", 32'(miss_ready), 32'd1);
        check("drain_no_fill", 32'(fill_valid), 32'd0);
        check("drain_no_fault", 32'(fault_valid), 32'd0);
        @(negedge clk);
        check("drain_no_fill2", 32'(fill_valid), 32'd0);

        // Asynchronous reset in the middle of a PDE read.
        start_miss(32'h0040_3ABC, 1'b1);
        check("pre_rst_req", 32'(mem_req), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("arst_req", 32'(mem_req), 32'd0);
        check("arst_addr", mem_addr, 32'd0);
        check("arst_ready", 32'(miss_ready), 32'd1);
        check("arst_fault_addr", fault_addr, 32'd0);
        check("arst_fault_write", 32'(fault_write), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        walk(32'h0040_3ABC, 32'h0000_4001, 32'h0000_0A13);
        check("arst_counter", 32'(fill_index), 32'd4);
        fill_ready = 1'b1;
        @(negedge clk);
        fill_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
